// File: rtl/mux_pipe.sv
// Registered N:1 operand select with a valid/ready handshake and a two-entry skid buffer.
// Out-of-range selects capture RESET_VALUE and raise a sticky error flag.
module mux_pipe #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_INPUTS  = 4,
    parameter int               SEL_W       = $clog2(NUM_INPUTS),
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_INPUTS*WIDTH-1:0] inputs,
    input  logic [SEL_W-1:0]            select,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sel_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

    localparam logic [SEL_W:0] NUM_IN_L = NUM_INPUTS[SEL_W:0];

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] main_nxt_s;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] skid_nxt_s;
    logic [WIDTH-1:0] word_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             sel_err_r;
    logic             sel_ok_s;
    logic             accept_s;
    logic             pop_s;

    function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
        return ({1'b0, sel} < NUM_IN_L);
    endfunction

    assign sel_ok_s  = sel_in_range(select);
    assign accept_s  = in_valid & in_ready_r;
    assign pop_s     = out_valid_r & out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign sel_err   = sel_err_r;

    // Select the addressed input slice; no match leaves the reset value in place.
    always_comb begin
        word_s = RESET_VALUE;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            word_s = (select == SEL_W'(k)) ? inputs[k*WIDTH +: WIDTH] : word_s;
        end
    end

    // Buffer occupancy and data movement; flush wins over accept and pop.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ONE;
                        main_nxt_s  = word_s;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && pop_s) begin
                        state_nxt_s = ONE;
                        main_nxt_s  = word_s;
                    end else if (accept_s) begin
                        state_nxt_s = TWO;
                        skid_nxt_s  = word_s;
                    end else if (pop_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                TWO: begin
                    if (pop_s) begin
                        state_nxt_s = ONE;
                        main_nxt_s  = skid_r;
                    end else begin
                        state_nxt_s = TWO;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State, data and handshake registers; ready/valid are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            main_r      <= RESET_VALUE;
            skid_r      <= RESET_VALUE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sel_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            main_r      <= main_nxt_s;
            skid_r      <= skid_nxt_s;
            in_ready_r  <= (state_nxt_s != TWO);
            out_valid_r <= (state_nxt_s != EMPTY);
            sel_err_r   <= sel_err_r | (accept_s & ~sel_ok_s);
        end
    end

endmodule

// File: tb/tb_mux_pipe.sv
// Directed bench for mux_pipe: queue-based occupancy model plus hand-computed expectations.
// A second instance with three inputs covers out-of-range select behaviour.
module tb_mux_pipe;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [4*W-1:0] inputs;
    logic [1:0]     select;
    logic           in_valid;
    logic           flush;
    logic           out_ready;
    logic           in_ready;
    logic           out_valid;
    logic           sel_err;
    logic [W-1:0]   out_data;

    logic [3*W-1:0] inputs3;
    logic [1:0]     select3;
    logic           in_valid3;
    logic           flush3;
    logic           out_ready3;
    logic           in_ready3;
    logic           out_valid3;
    logic           sel_err3;
    logic [W-1:0]   out_data3;

    mux_pipe #(.WIDTH(W), .NUM_INPUTS(4), .RESET_VALUE(32'h0)) dut4 (
        .clk(clk), .rst_n(rst_n), .inputs(inputs), .select(select),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err)
    );

    mux_pipe #(.WIDTH(W), .NUM_INPUTS(3), .RESET_VALUE(32'h0)) dut3 (
        .clk(clk), .rst_n(rst_n), .inputs(inputs3), .select(select3),
        .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .sel_err(sel_err3)
    );

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last;
    bit           cmp_en   = 1'b0;
    logic [W-1:0] stream_exp[4];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_word(input logic [4*W-1:0] v, input int s, input int n);
        if (s < n) return v[s*W +: W];
        return 32'h0;
    endfunction

    // Model: a FIFO of at most two words, front is what the output shows.
    task automatic tick();
        bit           acc;
        bit           pop;
        logic [W-1:0] w;
        acc = in_valid && (mq.size() < 2);
        pop = out_ready && (mq.size() != 0);
        w   = exp_word(inputs, int'(select), 4);
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(w);
        end
        if (mq.size() != 0) m_last = mq[0];
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_last = 32'h0;
    endtask

    // Every-cycle comparison of the N=4 instance against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid", 32'(out_valid), 32'(mq.size() != 0));
            check("ready", 32'(in_ready), 32'(mq.size() < 2));
            if (mq.size() != 0) check("data", out_data, mq[0]);
            else                check("held", out_data, m_last);
            check("sel_err4", 32'(sel_err), 32'h0);
        end
    end

    initial begin
        stream_exp[0] = 32'h11;
        stream_exp[1] = 32'h22;
        stream_exp[2] = 32'h33;
        stream_exp[3] = 32'h44;
        rst_n      = 1'b1;
        inputs     = {32'h44, 32'h33, 32'h22, 32'h11};
        select     = 2'd0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        inputs3    = {32'h33, 32'h22, 32'h11};
        select3    = 2'd0;
        in_valid3  = 1'b0;
        flush3     = 1'b0;
        out_ready3 = 1'b0;
        model_reset();
        #3 rst_n = 1'b0;
        #9;
        check("rst_data", out_data, 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        check("rst_err", 32'(sel_err), 32'h0);
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Latency: select 2 accepted, visible after one edge, gone the next.
        select = 2'd2; in_valid = 1'b1;
        select3 = 2'd3; in_valid3 = 1'b1;
        tick();
        in_valid = 1'b0; in_valid3 = 1'b0;
        at_neg();
        check("lat_data", out_data, 32'h33);
        check("lat_valid", 32'(out_valid), 32'h1);
        check("oor_data", out_data3, 32'h0);
        check("oor_valid", 32'(out_valid3), 32'h1);
        check("oor_err", 32'(sel_err3), 32'h1);
        tick();
        at_neg();
        check("lat_drop", 32'(out_valid), 32'h0);
        check("lat_hold", out_data, 32'h33);

        // Sticky select error survives a flush.
        flush3 = 1'b1;
        tick();
        flush3 = 1'b0;
        at_neg();
        check("oor_flush_err", 32'(sel_err3), 32'h1);
        check("oor_flush_valid", 32'(out_valid3), 32'h0);

        // Streaming at one word per cycle.
        for (int i = 0; i < 4; i++) begin
            select = 2'(i); in_valid = 1'b1;
            tick();
            at_neg();
            check("stream_data", out_data, stream_exp[i]);
            check("stream_ready", 32'(in_ready), 32'h1);
        end
        in_valid = 1'b0;
        tick();

        // Stall: A and B fill the buffer, C waits upstream.
        out_ready = 1'b0; in_valid = 1'b1;
        select = 2'd0; tick();
        select = 2'd1; tick();
        select = 2'd2;
        at_neg();
        check("skid_ready", 32'(in_ready), 32'h0);
        check("skid_data", out_data, 32'h11);
        tick(); tick();
        at_neg();
        check("skid_stable", out_data, 32'h11);
        out_ready = 1'b1;
        tick();
        at_neg();
        check("drain_b", out_data, 32'h22);
        check("drain_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        at_neg();
        check("drain_c", out_data, 32'h33);
        tick();

        // Flush from TWO with pop and offer asserted.
        out_ready = 1'b0; in_valid = 1'b1;
        select = 2'd3; tick();
        select = 2'd0; tick();
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        at_neg();
        check("flush_valid", 32'(out_valid), 32'h0);
        check("flush_ready", 32'(in_ready), 32'h1);
        check("flush_keep", out_data, 32'h44);
        tick(); tick();

        // Flush from ONE discards a word accepted on the same edge.
        in_valid = 1'b1; select = 2'd1; tick();
        flush = 1'b1; select = 2'd2; tick();
        flush = 1'b0; in_valid = 1'b0;
        at_neg();
        check("flush1_valid", 32'(out_valid), 32'h0);
        check("flush1_keep", out_data, 32'h22);
        tick();

        // Asynchronous reset while holding two words.
        out_ready = 1'b0; in_valid = 1'b1;
        select = 2'd1; tick();
        select = 2'd2; tick();
        in_valid = 1'b0;
        at_neg();
        cmp_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_data", out_data, 32'h0);
        check("arst_ready", 32'(in_ready), 32'h1);
        check("arst_err3", 32'(sel_err3), 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1; cmp_en = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; select = 2'd3;
        tick();
        in_valid = 1'b0;
        at_neg();
        check("post_rst", out_data, 32'h44);
        tick();
        at_neg();
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_pipe.md
# mux_pipe

Parametrised, registered N:1 operand-select multiplexer with a valid/ready handshake and a two-entry skid buffer. It is the next generation of the pipeline's combinational 2:1 32-bit select. Width and input count are configurable, out-of-range selects are detected, and the selected word is registered so it can sit on a stage boundary of the RV32IM pipeline, for example ALU operand or writeback source select. Downstream stalls are absorbed without losing data and without a combinational ready path from output to input.

## Interface
- WIDTH, 32, data width of each input and of OUTPUT
- NUM_INPUTS, 4, number of selectable inputs (≥2)
- SEL_W, $clog2(NUM_INPUTS), width of SELECT
- RESET_VALUE, 0, value of OUTPUT after reset and of the selected word when SELECT is out of range
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset
- INPUTS  input  NUM_INPUTS*WIDTH  flattened inputs; input k = INPUTS[k*WIDTH +: WIDTH]
- SELECT  input  SEL_W  index of input to capture; sampled with IN_VALID
- IN_VALID  input  1  upstream offers a word
- IN_READY  output  1  block can accept a word this cycle
- FLUSH  input  1  synchronous clear of all buffered words
- OUTPUT  output  WIDTH  registered selected word
- OUT_VALID  output  1  OUTPUT holds a valid word
- OUT_READY  input  1  downstream consumes OUTPUT this cycle
- SEL_ERR  output  1  sticky flag: an out-of-range SELECT was accepted

## Operation
- Accept = IN_VALID & IN_READY. Pop = OUT_VALID & OUT_READY.
- Captured word = INPUTS slice SELECT if SELECT < NUM_INPUTS, otherwise RESET_VALUE. An accepted out-of-range SELECT sets SEL_ERR, which is cleared only by reset. FLUSH does not clear it.
- Storage: main register (drives OUTPUT) and skid register. States:
  - EMPTY
  - ONE: main valid
  - TWO: main and skid valid
- Transitions:
  - EMPTY: accept → ONE, main ← word.
  - ONE: accept & !pop → TWO, skid ← word. Pop & !accept → EMPTY. Accept & pop → ONE, main ← word. Neither → ONE, hold.
  - TWO: accept is impossible. Pop → ONE, main ← skid. No pop → hold.
- OUT_VALID = state ≠ EMPTY.
- IN_READY = state ≠ TWO, driven from a register. No combinational path from OUT_READY to IN_READY.
- FLUSH has priority over all other events:
  - Next state is EMPTY.
  - A word accepted in the same cycle is discarded, but its SEL_ERR effect still applies.
  - OUTPUT keeps its last value.
- OUTPUT holds its last value when EMPTY. It never changes while OUT_VALID & !OUT_READY.
- Words leave in acceptance order. None are dropped or duplicated, except on FLUSH.

## Timing
- Reset (RESET low, asynchronous): state EMPTY, OUTPUT = RESET_VALUE, OUT_VALID = 0, IN_READY = 1, SEL_ERR = 0. RESET asserted mid-transfer discards all buffered words immediately.
- First rising edge after RESET deasserts may accept a word.
- Latency: a word accepted at edge n is on OUTPUT with OUT_VALID = 1 after edge n.
- Throughput: 1 word/cycle while OUT_READY is held high.
- IN_READY falls the cycle after the second buffered word is captured. It rises the cycle after the pop that leaves TWO.
- INPUTS and SELECT are sampled only at accepting edges. Changes at other times have no effect.

## Test plan
- Reset and latency:
  - Stimulus: WIDTH=32, NUM_INPUTS=4, RESET low, then high. Drive INPUTS = {0x44, 0x33, 0x22, 0x11} (input 0 = 0x11), SELECT=2, IN_VALID=1 for one cycle, OUT_READY=1.
  - Required: OUTPUT=0, OUT_VALID=0 during reset. One cycle after the accept, OUTPUT=0x33 and OUT_VALID=1. The cycle after that, OUT_VALID=0.
- Streaming:
  - Stimulus: SELECT=0,1,2,3 on consecutive cycles, OUT_READY=1.
  - Required: OUTPUT=0x11, 0x22, 0x33, 0x44 on consecutive cycles; IN_READY stays 1.
- Stall/skid:
  - Stimulus: OUT_READY=0; offer A (sel 0), B (sel 1), C (sel 2) back to back.
  - Required: A and B accepted, then IN_READY=0 and C is held upstream. OUTPUT=0x11 stays stable.
  - Then raise OUT_READY: outputs 0x11, 0x22, 0x33 in order.
- Out-of-range select:
  - Stimulus: NUM_INPUTS=3, SELECT=3 accepted.
  - Required: OUTPUT=RESET_VALUE, SEL_ERR=1, and SEL_ERR stays 1 through a subsequent FLUSH.
- Flush with simultaneous accept:
  - Stimulus: state TWO, then FLUSH=1 together with OUT_READY=1 (and IN_VALID=1 if IN_READY were high).
  - Required: next cycle OUT_VALID=0, IN_READY=1, no stale word ever emitted.
- Asynchronous reset mid-stall:
  - Stimulus: drop RESET between clock edges while in state TWO.
  - Required: OUT_VALID=0 and OUTPUT=RESET_VALUE immediately, before the next edge.
